// File: rtl/page_table_walker_pkg.sv
// -----------------------------------------------------------------------------
// ptw_pkg
// Shared definitions for the Sv39/Sv48 page-table walker:
//   - walker FSM state encoding
//   - PTE field positions and page geometry constants
//   - Sysbus request-tag field values
//   - level_shift(): bit position of the VPN field for a given level
// -----------------------------------------------------------------------------
package ptw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    CHECK,
    DONE
  } ptw_state_e;

  // PTE bit positions
  localparam int PTE_V      = 0;
  localparam int PTE_R      = 1;
  localparam int PTE_W      = 2;
  localparam int PTE_X      = 3;
  localparam int PTE_PPN_LO = 10;
  localparam int PTE_PPN_HI = 53;

  // Page geometry
  localparam int PPN_WIDTH  = 44;
  localparam int PAGE_SHIFT = 12;
  localparam int VPN_BITS   = 9;

  // Sysbus tag fields
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  // Lowest vaddr bit of vpn[lvl]; also the width of the page offset at that level
  function automatic int unsigned level_shift(input int unsigned lvl);
    return PAGE_SHIFT + VPN_BITS * lvl;
  endfunction

endpackage

// File: rtl/page_table_walker_pte_check.sv
// -----------------------------------------------------------------------------
// pte_check
// Combinational decode of one PTE fetched at level i_lvl.
//   i_pte        64-bit page-table entry
//   i_lvl        level the PTE was fetched at (LEVELS-1 = root)
//   i_vaddr      virtual address being translated
//   o_leaf       PTE is a leaf (R or X set)
//   o_fault      invalid, W-without-R, misaligned superpage, or non-leaf at level 0
//   o_next_base  next-level table base (ppn << 12)
//   o_paddr      translated address for a leaf at this level
// -----------------------------------------------------------------------------
module pte_check
  import ptw_pkg::*;
#(
  parameter int LEVELS   = 3,
  parameter int VA_WIDTH = 12 + 9 * LEVELS,
  parameter int PA_WIDTH = 56,
  parameter int LVL_W    = 2
) (
  input  logic [63:0]          i_pte,
  input  logic [LVL_W-1:0]     i_lvl,
  input  logic [VA_WIDTH-1:0]  i_vaddr,
  output logic                 o_leaf,
  output logic                 o_fault,
  output logic [PA_WIDTH-1:0]  o_next_base,
  output logic [PA_WIDTH-1:0]  o_paddr
);

  localparam int FULL_W = PPN_WIDTH + PAGE_SHIFT;

  logic [PPN_WIDTH-1:0] w_ppn;
  logic [FULL_W-1:0]    w_ppn_addr;
  logic [FULL_W-1:0]    w_off_mask;
  logic [FULL_W-1:0]    w_vaddr_ext;
  logic                 w_leaf;
  logic                 w_misaligned;
  logic                 w_unused_bits;

  assign w_ppn       = i_pte[PTE_PPN_HI:PTE_PPN_LO];
  assign w_ppn_addr  = {w_ppn, {PAGE_SHIFT{1'b0}}};
  assign w_vaddr_ext = FULL_W'(i_vaddr);

  // Offset mask covers the page offset of a superpage at this level
  // (12 bits at level 0, 21 at level 1, 30 at level 2, ...).
  assign w_off_mask  = (FULL_W'(1) << level_shift(32'(i_lvl))) - FULL_W'(1);

  assign w_leaf       = i_pte[PTE_R] | i_pte[PTE_X];
  // The low 12 bits of w_ppn_addr are zero, so this tests ppn[9*lvl-1:0].
  assign w_misaligned = (i_lvl != '0) && (|(w_ppn_addr & w_off_mask));

  assign o_leaf      = w_leaf;
  assign o_fault     = !i_pte[PTE_V]
                     || (i_pte[PTE_W] && !i_pte[PTE_R])
                     || (w_leaf && w_misaligned)
                     || (!w_leaf && (i_lvl == '0));
  assign o_next_base = PA_WIDTH'(w_ppn_addr);
  assign o_paddr     = PA_WIDTH'((w_ppn_addr & ~w_off_mask) | (w_vaddr_ext & w_off_mask));

  // Reserved / software / A-D bits play no part in translation here.
  assign w_unused_bits = ^{i_pte[63:PTE_PPN_HI+1], i_pte[PTE_PPN_LO-1:PTE_X+1]};

endmodule

// File: rtl/page_table_walker.sv
// -----------------------------------------------------------------------------
// page_table_walker
// Sv39/Sv48 hardware page-table walker between address translation and the
// Sysbus. Each level reads one full line burst and keeps the beat holding the
// PTE, then decodes it with pte_check.
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        translation request (req_ready = walker idle)
//   req_vaddr, satp_ppn        virtual address and root PPN, sampled at accept
//   resp_valid/resp_ready      result handshake
//   resp_paddr/fault/perm      physical address (0 on fault), fault, {X,W,R,V}
//   bus_reqcyc/reqack/req/tag  Sysbus line-read request
//   bus_respcyc/respack/resp   Sysbus response beats (resptag ignored)
// -----------------------------------------------------------------------------
module page_table_walker
  import ptw_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LEVELS         = 3,
  parameter int LINE_BEATS     = 8,
  parameter int PTESIZE        = 8,
  parameter int PA_WIDTH       = 56,
  parameter int VA_WIDTH       = 12 + 9 * LEVELS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VA_WIDTH-1:0]       req_vaddr,
  input  logic [PPN_WIDTH-1:0]      satp_ppn,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [PA_WIDTH-1:0]       resp_paddr,
  output logic                      resp_fault,
  output logic [3:0]                resp_perm,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int PTE_SHIFT  = $clog2(PTESIZE);
  localparam int LINE_SHIFT = $clog2(LINE_BEATS * PTESIZE);
  localparam int CNT_W      = $clog2(LINE_BEATS);

  ptw_state_e                r_state;
  logic [VA_WIDTH-1:0]       r_vaddr;
  logic [PA_WIDTH-1:0]       r_base;
  logic [LVL_W-1:0]          r_lvl;
  logic [CNT_W-1:0]          r_sel;
  logic [CNT_W-1:0]          r_cnt;
  logic [63:0]               r_pte;
  logic                      r_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] r_bus_req;
  logic                      r_resp_valid;
  logic                      r_resp_fault;
  logic [PA_WIDTH-1:0]       r_resp_paddr;
  logic [3:0]                r_resp_perm;

  logic [VPN_BITS-1:0]       w_vpn;
  logic [PA_WIDTH-1:0]       w_pte_addr;
  logic [PA_WIDTH-1:0]       w_line_addr;
  logic [CNT_W-1:0]          w_sel;
  logic                      w_leaf;
  logic                      w_fault;
  logic [PA_WIDTH-1:0]       w_next_base;
  logic [PA_WIDTH-1:0]       w_paddr;
  logic                      w_unused_tag;

  // PTE address for the current level and the line that contains it
  assign w_vpn       = VPN_BITS'(r_vaddr >> level_shift(32'(r_lvl)));
  assign w_pte_addr  = r_base + (PA_WIDTH'(w_vpn) << PTE_SHIFT);
  assign w_line_addr = {w_pte_addr[PA_WIDTH-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
  assign w_sel       = w_pte_addr[LINE_SHIFT-1:PTE_SHIFT];

  pte_check #(
    .LEVELS   (LEVELS),
    .VA_WIDTH (VA_WIDTH),
    .PA_WIDTH (PA_WIDTH),
    .LVL_W    (LVL_W)
  ) u_pte_check (
    .i_pte       (r_pte),
    .i_lvl       (r_lvl),
    .i_vaddr     (r_vaddr),
    .o_leaf      (w_leaf),
    .o_fault     (w_fault),
    .o_next_base (w_next_base),
    .o_paddr     (w_paddr)
  );

  // Beats are acked in IDLE too, so a burst cut short by reset drains harmlessly.
  assign bus_respack  = bus_respcyc && ((r_state == RESP) || (r_state == IDLE));
  assign req_ready    = (r_state == IDLE);
  assign bus_reqcyc   = r_bus_reqcyc;
  assign bus_req      = r_bus_req;
  assign bus_reqtag   = BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});
  assign resp_valid   = r_resp_valid;
  assign resp_fault   = r_resp_fault;
  assign resp_paddr   = r_resp_paddr;
  assign resp_perm    = r_resp_perm;
  assign w_unused_tag = ^bus_resptag;

  // NOTE: every register here uses <= so all state advances together on the
  // edge; a blocking = would let later statements see this cycle's new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_vaddr      <= '0;
      r_base       <= '0;
      r_lvl        <= '0;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_pte        <= '0;
      r_bus_reqcyc <= 1'b0;
      r_bus_req    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_perm  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_vaddr <= req_vaddr;
            r_base  <= PA_WIDTH'({satp_ppn, {PAGE_SHIFT{1'b0}}});
            r_lvl   <= LVL_W'(LEVELS - 1);
            r_state <= REQ;
          end
        end

        // First cycle launches the request; bus_req is then frozen until acked.
        REQ: begin
          if (!r_bus_reqcyc) begin
            r_bus_reqcyc <= 1'b1;
            r_bus_req    <= BUS_DATA_WIDTH'(w_line_addr);
            r_sel        <= w_sel;
          end else if (bus_reqack) begin
            r_bus_reqcyc <= 1'b0;
            r_state      <= RESP;
          end
        end

        RESP: begin
          if (bus_respcyc) begin
            if (r_cnt == r_sel) begin
              r_pte <= bus_resp[63:0];
            end
            if (r_cnt == CNT_W'(LINE_BEATS - 1)) begin
              r_cnt   <= '0;
              r_state <= CHECK;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (w_fault) begin
            r_resp_fault <= 1'b1;
            r_resp_paddr <= '0;
            r_resp_perm  <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end else if (w_leaf) begin
            r_resp_fault <= 1'b0;
            r_resp_paddr <= w_paddr;
            r_resp_perm  <= r_pte[PTE_X:PTE_V];
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_base  <= w_next_base;
            r_lvl   <= r_lvl - LVL_W'(1);
            r_state <= REQ;
          end
        end

        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// -----------------------------------------------------------------------------
// tb_page_table_walker
// Directed bench for page_table_walker. A Sv39 instance and a Sv48 instance
// share one set of stimulus signals; use4 routes the handshakes to one of them
// and selects which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        use4;
  logic        req_valid;
  logic [47:0] req_vaddr;
  logic [43:0] satp_ppn;
  logic        resp_ready;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  always #5 clk = ~clk;

  // Per-instance gated inputs
  logic d3_req_valid, d3_resp_ready, d3_bus_reqack, d3_bus_respcyc;
  logic d4_req_valid, d4_resp_ready, d4_bus_reqack, d4_bus_respcyc;
  assign d3_req_valid   = req_valid   & ~use4;
  assign d3_resp_ready  = resp_ready  & ~use4;
  assign d3_bus_reqack  = bus_reqack  & ~use4;
  assign d3_bus_respcyc = bus_respcyc & ~use4;
  assign d4_req_valid   = req_valid   & use4;
  assign d4_resp_ready  = resp_ready  & use4;
  assign d4_bus_reqack  = bus_reqack  & use4;
  assign d4_bus_respcyc = bus_respcyc & use4;

  logic        d3_req_ready, d3_resp_valid, d3_resp_fault, d3_bus_reqcyc, d3_bus_respack;
  logic [55:0] d3_resp_paddr;
  logic [3:0]  d3_resp_perm;
  logic [63:0] d3_bus_req;
  logic [12:0] d3_bus_reqtag;
  logic        d4_req_ready, d4_resp_valid, d4_resp_fault, d4_bus_reqcyc, d4_bus_respack;
  logic [55:0] d4_resp_paddr;
  logic [3:0]  d4_resp_perm;
  logic [63:0] d4_bus_req;
  logic [12:0] d4_bus_reqtag;

  page_table_walker #(.LEVELS(3)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (d3_req_valid),
    .req_ready   (d3_req_ready),
    .req_vaddr   (req_vaddr[38:0]),
    .satp_ppn    (satp_ppn),
    .resp_valid  (d3_resp_valid),
    .resp_ready  (d3_resp_ready),
    .resp_paddr  (d3_resp_paddr),
    .resp_fault  (d3_resp_fault),
    .resp_perm   (d3_resp_perm),
    .bus_reqcyc  (d3_bus_reqcyc),
    .bus_reqack  (d3_bus_reqack),
    .bus_req     (d3_bus_req),
    .bus_reqtag  (d3_bus_reqtag),
    .bus_respcyc (d3_bus_respcyc),
    .bus_respack (d3_bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  page_table_walker #(.LEVELS(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (d4_req_valid),
    .req_ready   (d4_req_ready),
    .req_vaddr   (req_vaddr),
    .satp_ppn    (satp_ppn),
    .resp_valid  (d4_resp_valid),
    .resp_ready  (d4_resp_ready),
    .resp_paddr  (d4_resp_paddr),
    .resp_fault  (d4_resp_fault),
    .resp_perm   (d4_resp_perm),
    .bus_reqcyc  (d4_bus_reqcyc),
    .bus_reqack  (d4_bus_reqack),
    .bus_req     (d4_bus_req),
    .bus_reqtag  (d4_bus_reqtag),
    .bus_respcyc (d4_bus_respcyc),
    .bus_respack (d4_bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  // Observed view of the selected instance
  logic        m_req_ready, m_resp_valid, m_resp_fault, m_bus_reqcyc, m_bus_respack;
  logic [55:0] m_resp_paddr;
  logic [3:0]  m_resp_perm;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  assign m_req_ready   = use4 ? d4_req_ready   : d3_req_ready;
  assign m_resp_valid  = use4 ? d4_resp_valid  : d3_resp_valid;
  assign m_resp_fault  = use4 ? d4_resp_fault  : d3_resp_fault;
  assign m_resp_paddr  = use4 ? d4_resp_paddr  : d3_resp_paddr;
  assign m_resp_perm   = use4 ? d4_resp_perm   : d3_resp_perm;
  assign m_bus_reqcyc  = use4 ? d4_bus_reqcyc  : d3_bus_reqcyc;
  assign m_bus_respack = use4 ? d4_bus_respack : d3_bus_respack;
  assign m_bus_req     = use4 ? d4_bus_req     : d3_bus_req;
  assign m_bus_reqtag  = use4 ? d4_bus_reqtag  : d3_bus_reqtag;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Completed bus request handshakes
  always @(posedge clk) begin
    if (m_bus_reqcyc && bus_reqack) n_txn++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req_ready"},  m_req_ready,  64'd1);
    check({tag, " resp_valid"}, m_resp_valid, 64'd0);
    check({tag, " resp_fault"}, m_resp_fault, 64'd0);
    check({tag, " resp_paddr"}, m_resp_paddr, 64'd0);
    check({tag, " resp_perm"},  m_resp_perm,  64'd0);
    check({tag, " bus_reqcyc"}, m_bus_reqcyc, 64'd0);
    check({tag, " bus_req"},    m_bus_req,    64'd0);
  endtask

  // Offer one request; scramble the sampled inputs afterwards so that only
  // the values present at accept can produce the right walk.
  task automatic start_req(input string tag, input logic [43:0] satp, input logic [47:0] va);
    check({tag, " req_ready idle"}, m_req_ready, 64'd1);
    req_valid = 1'b1;
    satp_ppn  = satp;
    req_vaddr = va;
    tick();
    req_valid = 1'b0;
    satp_ppn  = 44'hF_FFFF_FFFF;
    req_vaddr = '1;
    check({tag, " req_ready busy"}, m_req_ready, 64'd0);
  endtask

  // Wait for a line request, hold off the ack, then return one burst with the
  // PTE in beat 'sel' and invalid filler everywhere else.
  task automatic serve_line(input string tag, input logic [63:0] exp_line, input int sel,
                            input logic [63:0] pte, input int ack_delay);
    int cyc = 0;
    while (!m_bus_reqcyc && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " bus_reqcyc"}, m_bus_reqcyc, 64'd1);
    check({tag, " bus_req"},    m_bus_req,    exp_line);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check({tag, " reqcyc held"}, m_bus_reqcyc, 64'd1);
      check({tag, " req held"},    m_bus_req,    exp_line);
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    check({tag, " reqcyc drop"}, m_bus_reqcyc, 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = (i == sel) ? pte : (64'h0BAD_0000_0000_0000 | (64'(i) << 8));
      #1;
      check({tag, " respack"}, m_bus_respack, 64'd1);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  task automatic finish_resp(input string tag, input logic exp_fault, input logic [55:0] exp_paddr,
                             input logic chk_perm, input logic [3:0] exp_perm, input int ready_delay);
    int cyc = 0;
    while (!m_resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " resp_valid"}, m_resp_valid, 64'd1);
    check({tag, " resp_fault"}, m_resp_fault, 64'(exp_fault));
    check({tag, " resp_paddr"}, m_resp_paddr, 64'(exp_paddr));
    if (chk_perm) check({tag, " resp_perm"}, m_resp_perm, 64'(exp_perm));
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check({tag, " valid held"}, m_resp_valid, 64'd1);
      check({tag, " paddr held"}, m_resp_paddr, 64'(exp_paddr));
      check({tag, " fault held"}, m_resp_fault, 64'(exp_fault));
      check({tag, " no accept"},  m_req_ready,  64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, " valid drop"}, m_resp_valid, 64'd0);
    check({tag, " back idle"},  m_req_ready,  64'd1);
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    use4        = 1'b0;
    req_valid   = 1'b0;
    req_vaddr   = '0;
    satp_ppn    = '0;
    resp_ready  = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    tick();
    tick();
    check_reset_state("reset");
    check("reset reqtag",  m_bus_reqtag,  64'h1100);
    check("reset respack", m_bus_respack, 64'd0);
    reset = 1'b0;
    tick();

    // Single-level 1 GiB superpage
    base = n_txn;
    start_req("sp", 44'h80000, 48'h4000_1234);
    serve_line("sp root", 64'h8000_0000, 1, 64'h1000_000F, 0);
    finish_resp("sp", 1'b0, 56'h4000_1234, 1'b1, 4'hF, 0);
    check("sp txns", 64'(n_txn - base), 64'd1);

    // Reset after beat 3 of the root burst; leftover beats drain in IDLE
    start_req("rst", 44'h80000, 48'h4000_1234);
    begin
      int cyc = 0;
      while (!m_bus_reqcyc && cyc < 20) begin
        tick();
        cyc++;
      end
    end
    check("rst reqcyc", m_bus_reqcyc, 64'd1);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h0BAD_0000_0000_0000;
      tick();
    end
    bus_respcyc = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst after");
    for (int i = 4; i < 8; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h0BAD_0000_0000_0000;
      #1;
      check("rst drain respack", m_bus_respack, 64'd1);
      tick();
    end
    bus_respcyc = 1'b0;
    check("rst still idle", m_req_ready, 64'd1);
    base = n_txn;
    start_req("rst walk", 44'h80000, 48'h4000_1234);
    serve_line("rst walk root", 64'h8000_0000, 1, 64'h1000_000F, 0);
    finish_resp("rst walk", 1'b0, 56'h4000_1234, 1'b1, 4'hF, 0);
    check("rst walk txns", 64'(n_txn - base), 64'd1);

    // Three-level walk with ack and resp_ready backpressure
    base = n_txn;
    start_req("l3", 44'h80000, 48'h4000_1234);
    serve_line("l3 root", 64'h8000_0000, 1, 64'h2000_0401, 5);
    serve_line("l3 mid",  64'h8000_1000, 0, 64'h2000_0801, 0);
    serve_line("l3 leaf", 64'h8000_2000, 1, 64'h048D_140B, 0);
    finish_resp("l3", 1'b0, 56'h1234_5234, 1'b1, 4'hB, 4);
    check("l3 txns", 64'(n_txn - base), 64'd3);

    // Faults
    base = n_txn;
    start_req("f zero", 44'h80000, 48'h4000_1234);
    serve_line("f zero root", 64'h8000_0000, 1, 64'h0, 0);
    finish_resp("f zero", 1'b1, 56'h0, 1'b0, 4'h0, 0);
    check("f zero txns", 64'(n_txn - base), 64'd1);

    start_req("f misalign", 44'h80000, 48'h4000_1234);
    serve_line("f misalign root", 64'h8000_0000, 1, 64'h1000_040F, 0);
    finish_resp("f misalign", 1'b1, 56'h0, 1'b0, 4'h0, 0);

    start_req("f wonly", 44'h80000, 48'h4000_1234);
    serve_line("f wonly root", 64'h8000_0000, 1, 64'h5, 0);
    finish_resp("f wonly", 1'b1, 56'h0, 1'b0, 4'h0, 0);

    // Pointer PTE at the last level
    start_req("f l0ptr", 44'h80000, 48'h4000_1234);
    serve_line("f l0ptr root", 64'h8000_0000, 1, 64'h2000_0401, 0);
    serve_line("f l0ptr mid",  64'h8000_1000, 0, 64'h2000_0801, 0);
    serve_line("f l0ptr leaf", 64'h8000_2000, 1, 64'h2000_0801, 0);
    finish_resp("f l0ptr", 1'b1, 56'h0, 1'b0, 4'h0, 0);

    // Sv48: vpn3=2 puts the root PTE at root+16, beat 2
    use4 = 1'b1;
    tick();
    base = n_txn;
    start_req("l4", 44'h80000, 48'h0100_0000_3ABC);
    serve_line("l4 root", 64'h8000_0000, 2, 64'h2000_0401, 0);
    serve_line("l4 l2",   64'h8000_1000, 0, 64'h2000_0801, 0);
    serve_line("l4 l1",   64'h8000_2000, 0, 64'h2000_0C01, 0);
    serve_line("l4 l0",   64'h8000_3000, 3, 64'h1555_5407, 0);
    finish_resp("l4", 1'b0, 56'h5555_5ABC, 1'b1, 4'h7, 0);
    check("l4 txns", 64'(n_txn - base), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
